pe_vector_feeder: RTL and testbench

PE_VECTOR_FEEDER -- requirements
Module: pe_vector_feeder

---
 rtl/pe_vector_feeder.sv | 124 ++++++++++++
 tb/tb_pe_vector_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vector_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe_vector_feeder                                             |
// | Description : Packs a stream of lane words into a wide vector (lane 0 in   |
// |               the MSBs), closing on a full vector or on flush.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pe_vector_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] vec_data,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic [$clog2(ARRAY_SIZE):0]      vec_lanes,
    output logic [15:0]                      vec_count
);

    localparam int c_CNT_W  = $clog2(ARRAY_SIZE);
    localparam int c_LANE_W = c_CNT_W + 1;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t                                  r_state;
    logic [c_CNT_W-1:0]                      r_cnt;
    // Ascending packed range puts lane 0 in the most significant word.
    logic [0:ARRAY_SIZE-1][DATA_WIDTH-1:0]   r_buf;
    logic [0:ARRAY_SIZE-1][DATA_WIDTH-1:0]   w_buf_next;
    logic [0:ARRAY_SIZE-1][DATA_WIDTH-1:0]   r_vec;
    logic [c_LANE_W-1:0]                     r_pend_lanes;
    logic                                    r_vec_valid;
    logic [c_LANE_W-1:0]                     r_vec_lanes;
    logic [15:0]                             r_vec_count;

    logic                                    w_accept;
    logic                                    w_last;
    logic                                    w_close;
    logic                                    w_slot_free;
    logic [c_LANE_W-1:0]                     w_lanes_next;

    assign in_ready     = (r_state == S_FILL);
    assign w_accept     = in_valid && in_ready;
    assign w_last       = w_accept && (r_cnt == c_CNT_W'(ARRAY_SIZE - 1));
    assign w_close      = w_last || (flush && in_ready && ((r_cnt != '0) || w_accept));
    assign w_slot_free  = !r_vec_valid || vec_ready;
    assign w_lanes_next = c_LANE_W'(r_cnt) + c_LANE_W'(w_accept);

    // Buffer contents including a word accepted this cycle, so the closing
    // word lands in the output register on the same edge.
    always_comb begin
        w_buf_next = r_buf;
        if (w_accept) begin
            w_buf_next[r_cnt] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_pend_lanes <= '0;
            r_vec        <= '0;
            r_vec_valid  <= 1'b0;
            r_vec_lanes  <= '0;
            r_vec_count  <= '0;
        end else begin
            if (r_vec_valid && vec_ready) begin
                r_vec_valid <= 1'b0;
            end
            case (r_state)
                S_FILL: begin
                    if (w_close) begin
                        if (w_slot_free) begin
                            r_vec       <= w_buf_next;
                            r_vec_lanes <= w_lanes_next;
                            r_vec_valid <= 1'b1;
                            r_vec_count <= r_vec_count + 16'd1;
                            r_buf       <= '0;
                            r_cnt       <= '0;
                        end else begin
                            r_buf        <= w_buf_next;
                            r_pend_lanes <= w_lanes_next;
                            r_cnt        <= '0;
                            r_state      <= S_PEND;
                        end
                    end else if (w_accept) begin
                        r_buf <= w_buf_next;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_PEND: begin
                    // Slot is necessarily occupied here; vec_ready frees it.
                    if (vec_ready) begin
                        r_vec       <= r_buf;
                        r_vec_lanes <= r_pend_lanes;
                        r_vec_valid <= 1'b1;
                        r_vec_count <= r_vec_count + 16'd1;
                        r_buf       <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign vec_data  = r_vec;
    assign vec_valid = r_vec_valid;
    assign vec_lanes = r_vec_lanes;
    assign vec_count = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_pe_vector_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pe_vector_feeder                                          |
// | Description : Directed self-checking bench for pe_vector_feeder.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pe_vector_feeder;

    localparam int DW = 16;
    localparam int AS = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [DW*AS-1:0] vec_data;
    logic            vec_valid;
    logic            vec_ready;
    logic [7:0]      vec_lanes;
    logic [15:0]     vec_count;

    int n_pass  = 0;
    int n_total = 0;

    pe_vector_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .vec_data  (vec_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_lanes (vec_lanes),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return vec_data[(AS-i)*DW-1 -: DW];
    endfunction

    function automatic int lane_mism(input logic [DW*AS-1:0] e);
        int n = 0;
        for (int i = 0; i < AS; i++)
            if (vec_data[(AS-i)*DW-1 -: DW] !== e[(AS-i)*DW-1 -: DW]) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW*AS-1:0] exp_v;
        logic             early_v;
        int               drops;
        int               pulses;
        int               first_pulse;
        int               gap;
        logic [DW-1:0]    first_lane0;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; vec_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", vec_valid, 0);
        chk("rst_data_nz", |vec_data, 0);
        chk("rst_lanes", vec_lanes, 0);
        chk("rst_count", vec_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Full vector 0x0001..0x0080
        early_v = 1'b0;
        for (int i = 1; i <= AS; i++) begin
            push(DW'(i));
            if (i < AS) early_v |= vec_valid;
        end
        in_valid = 1'b0;
        chk("s1_no_early", early_v, 0);
        chk("s1_valid", vec_valid, 1);
        chk("s1_lane0", lane(0), 16'h0001);
        chk("s1_lane64", lane(64), 16'h0041);
        chk("s1_lane127", lane(127), 16'h0080);
        chk("s1_lanes", vec_lanes, 128);
        chk("s1_count", vec_count, 1);
        tick();
        chk("s1_pulse_end", vec_valid, 0);

        // 5 x 0xAAAA then flush alone
        for (int i = 0; i < 5; i++) push(16'hAAAA);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_v = '0;
        for (int i = 0; i < 5; i++) exp_v[(AS-i)*DW-1 -: DW] = 16'hAAAA;
        chk("s2_valid", vec_valid, 1);
        chk("s2_lanes", vec_lanes, 5);
        chk("s2_lane_diff", lane_mism(exp_v), 0);
        chk("s2_count", vec_count, 2);
        tick();

        // flush together with an accepted word includes that word
        push(16'h1111); push(16'h2222);
        flush = 1'b1;
        push(16'h5555);
        flush = 1'b0; in_valid = 1'b0;
        chk("s2b_lanes", vec_lanes, 3);
        chk("s2b_lane2", lane(2), 16'h5555);
        chk("s2b_lane3", lane(3), 16'h0000);
        chk("s2b_count", vec_count, 3);
        tick();

        // flush with empty buffer is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s3_no_valid", vec_valid, 0);
        tick();
        chk("s3_no_valid2", vec_valid, 0);
        chk("s3_count", vec_count, 3);

        // Backpressure: two full vectors with vec_ready low
        vec_ready = 1'b0;
        for (int i = 0; i < AS; i++) push(16'h0100 + DW'(i));
        chk("s4_a_valid", vec_valid, 1);
        chk("s4_a_count", vec_count, 4);
        chk("s4_a_in_ready", in_ready, 1);
        for (int i = 0; i < AS; i++) push(16'h0200 + DW'(i));
        chk("s4_pend_in_ready", in_ready, 0);
        chk("s4_held_lane0", lane(0), 16'h0100);
        chk("s4_held_lane127", lane(127), 16'h017F);
        chk("s4_held_count", vec_count, 4);
        push(16'hDEAD);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("s4_still_pend", in_ready, 0);
        chk("s4_still_held", lane(0), 16'h0100);
        vec_ready = 1'b1;
        tick();
        chk("s4_b_valid", vec_valid, 1);
        chk("s4_b_lane0", lane(0), 16'h0200);
        chk("s4_b_lane127", lane(127), 16'h027F);
        chk("s4_b_lanes", vec_lanes, 128);
        chk("s4_b_count", vec_count, 5);
        chk("s4_in_ready_back", in_ready, 1);
        tick();
        chk("s4_consumed", vec_valid, 0);

        // Continuous 256-word stream
        drops = 0; pulses = 0; first_pulse = -1; gap = -1; first_lane0 = '0;
        for (int i = 0; i < 2*AS; i++) begin
            if (!in_ready) drops++;
            push(16'h0300 + DW'(i));
            if (vec_valid) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse = i;
                    first_lane0 = lane(0);
                end else begin
                    gap = i - first_pulse;
                end
            end
        end
        in_valid = 1'b0;
        chk("s5_drops", drops, 0);
        chk("s5_pulses", pulses, 2);
        chk("s5_gap", gap, 128);
        chk("s5_first_lane0", first_lane0, 16'h0300);
        chk("s5_second_lane0", lane(0), 16'h0380);
        chk("s5_count", vec_count, 7);
        tick();
        chk("s5_end_valid", vec_valid, 0);

        // Reset mid-vector discards it
        for (int i = 0; i < 60; i++) push(16'h0400 + DW'(i));
        rst = 1'b1; flush = 1'b1;
        push(16'hBEEF);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("s6_rst_valid", vec_valid, 0);
        chk("s6_rst_data_nz", |vec_data, 0);
        chk("s6_rst_lanes", vec_lanes, 0);
        chk("s6_rst_count", vec_count, 0);
        chk("s6_rst_in_ready", in_ready, 1);
        for (int i = 0; i < AS; i++) push(16'h0500 + DW'(i));
        in_valid = 1'b0;
        chk("s6_valid", vec_valid, 1);
        chk("s6_lane0", lane(0), 16'h0500);
        chk("s6_lane127", lane(127), 16'h057F);
        chk("s6_lanes", vec_lanes, 128);
        chk("s6_count", vec_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
